// File: rtl/bus_resp.sv
// bus_resp: word-addressed 32-bit memory target on a strobe/ack bus.
// Ports: clk, reset (sync, active-high), strobe/rw/addr/d_in request side,
//        d_out/ack/err completion side, busy while a transaction is in flight.
// Latency: write or miss acks 1 cycle after accept; read hit acks WAIT+1 cycles after accept.
// Backpressure: initiator holds strobe until ack; dropping strobe during the wait aborts the read.
// Optional: define BUS_RESP_WPROT_EN to add a wprot input that refuses write hits with err=1.
module bus_resp #(
    parameter logic [31:0] BASE      = 32'h00001000,
    parameter int          SIZE_LOG2 = 10,
    parameter int          WAIT      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
`ifdef BUS_RESP_WPROT_EN
    input  logic        wprot,
`endif
    output logic [31:0] d_out,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << SIZE_LOG2;
    // Wait counter reload; only used when WAIT > 0, so the WAIT == 0 case is a don't-care.
    localparam logic [7:0] WAIT_LOAD = (WAIT > 0) ? 8'(WAIT - 1) : 8'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             cnt;
    logic [7:0]             cnt_nxt;
    logic [31:0]            dout_nxt;
    logic                   err_nxt;
    logic [31:0]            diff;
    logic                   hit;
    logic                   wp;
    logic                   accept;
    logic                   we;
    logic [SIZE_LOG2-1:0]   idx_now;
    logic [SIZE_LOG2-1:0]   idx_q;
    logic [SIZE_LOG2-1:0]   rd_idx;
    logic [31:0]            mem [DEPTH];

    // Unsigned difference: addresses below BASE wrap to huge values and miss.
    assign diff    = addr - BASE;
    assign hit     = (diff >> SIZE_LOG2) == 32'd0;
    assign idx_now = diff[SIZE_LOG2-1:0];
    assign accept  = (state == S_IDLE) && strobe;

`ifdef BUS_RESP_WPROT_EN
    assign wp = wprot;
`else
    assign wp = 1'b0;
`endif

    // Reset overrides a simultaneous accept, so the store is suppressed too.
    assign we = accept && rw && hit && !wp && !reset;

    // The address is only trusted at the accept edge; later read stages use the captured index.
    assign rd_idx = (state == S_IDLE) ? idx_now : idx_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx_now] <= d_in;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (strobe) begin
                    if (!hit || rw || (WAIT == 0)) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!strobe) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 8'd0) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the wait counter
    always_comb begin
        cnt_nxt  = 8'd0;
        dout_nxt = 32'd0;
        err_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (strobe) begin
                    if (!hit) begin
                        err_nxt = 1'b1;
                    end else if (rw) begin
                        err_nxt = wp;
                    end else if (WAIT == 0) begin
                        dout_nxt = mem[rd_idx];
                    end else begin
                        cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (strobe) begin
                    if (cnt == 8'd0) begin
                        dout_nxt = mem[rd_idx];
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= 8'd0;
            d_out <= 32'd0;
            err   <= 1'b0;
            ack   <= 1'b0;
            busy  <= 1'b0;
            idx_q <= '0;
        end else begin
            cnt   <= cnt_nxt;
            d_out <= dout_nxt;
            err   <= err_nxt;
            ack   <= (state_nxt == S_ACK);
            busy  <= (state_nxt != S_IDLE);
            if (accept) begin
                idx_q <= idx_now;
            end
        end
    end

endmodule

// File: doc/bus_resp.md
BUS_RESP -- requirements
Module: bus_resp

Interface
REQ-001 Parameter BASE, default 32'h00001000, first word address served.
REQ-002 Parameter SIZE_LOG2, default 10, log2 of words stored (legal 1..16).
REQ-003 Parameter WAIT, default 2, read wait states (legal 0..255).
REQ-004 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port strobe  input  1  request valid, held by initiator until ack.
REQ-007 Port rw  input  1  1 = write, 0 = read (same sense as core mem_rw).
REQ-008 Port addr  input  32  word address.
REQ-009 Port d_in  input  32  write data.
REQ-010 Port d_out  output  32  read data, valid only in ack cycle, else 0.
REQ-011 Port ack  output  1  one-cycle completion pulse.
REQ-012 Port err  output  1  qualifies ack; 1 = request refused.
REQ-013 Port busy  output  1  high in any state other than IDLE.

Function
REQ-014 States IDLE, WAIT, ACK, registered outputs; word-addressed storage of 2**SIZE_LOG2 x 32.
REQ-015 Hit: (addr - BASE), unsigned 32-bit, < 2**SIZE_LOG2; index = low SIZE_LOG2 bits of difference; addresses below BASE wrap large and miss.
REQ-016 IDLE + strobe, write, hit: d_in stored at index on that edge; next state ACK.
REQ-017 IDLE + strobe, read, hit, WAIT=0: next state ACK; d_out loaded with stored word.
REQ-018 IDLE + strobe, read, hit, WAIT>0: counter loaded WAIT-1, next state WAIT; d_out = stored word on exit.
REQ-019 WAIT: counter decrements each cycle; at 0 with strobe high go ACK, loading d_out.
REQ-020 WAIT + strobe low: abort to IDLE, no ack, no err.
REQ-021 IDLE + strobe, miss: no write, next state ACK with err=1, d_out=0.
REQ-022 ACK: ack=1 for exactly one cycle, strobe ignored, next state IDLE; back-to-back requests therefore spaced by at least one IDLE cycle.
REQ-023 Latency: write/miss ack one cycle after accept edge; read ack WAIT+1 cycles after accept edge.
REQ-024 addr, rw, d_in sampled only at accept edge; later changes have no effect on the transaction.
REQ-025 Read after write to same index returns new data; no read-during-write hazard since one transaction in flight.

Reset
REQ-026 reset high at an edge: state IDLE, ack=0, err=0, d_out=0, busy=0, counter=0.
REQ-027 reset overrides a simultaneous strobe; an in-flight read is dropped without ack.
REQ-028 Storage contents not cleared by reset; a write already committed at accept edge persists.

Configuration
REQ-029 Macro BUS_RESP_WPROT_EN defined: input port wprot (1 bit) exists; write hit with wprot=1 at accept edge performs no store and acks with err=1.
REQ-030 Macro BUS_RESP_WPROT_EN undefined: no wprot port; all write hits store and ack with err=0.

Verification
REQ-031 Reset, write addr 32'h1005 data 32'hDEADBEEF -> ack+err=0 one cycle after accept; read 32'h1005 -> ack 3 cycles after accept, d_out=32'hDEADBEEF.
REQ-032 Read addr 32'h0FFF and 32'h1400 (SIZE_LOG2=10) -> ack with err=1, d_out=0, storage unchanged.
REQ-033 Read 32'h1005 with WAIT=2, drop strobe one cycle after accept -> no ack, busy low next cycle, next request served normally.
REQ-034 WAIT=0 build: read 32'h1000 -> ack one cycle after accept; strobe held through ACK -> no second ack; re-accepted after IDLE cycle.
REQ-035 Assert reset during WAIT -> no ack, all outputs 0 next cycle; subsequent read returns pre-reset written data.
REQ-036 BUS_RESP_WPROT_EN, wprot=1, write 32'h1002 data 32'h12345678 -> err=1; read 32'h1002 returns prior value.
